// File: rtl/demux_pkg.sv
// Shared defaults, types and constants for the stream demultiplexer.
package demux_pkg;

    localparam int unsigned NUM_OUT_DEF = 3;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned SEL_W_DEF   = 2;
    localparam int unsigned ERR_W_DEF   = 8;

    // Entries held per output; two entries let a push and a pop overlap.
    localparam int unsigned FIFO_DEPTH  = 2;

    typedef logic [DATA_W_DEF-1:0] data_t;
    typedef logic [SEL_W_DEF-1:0]  sel_t;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO for one demux output. The head register doubles as the
// output payload, so it keeps its last value once the FIFO drains.
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] head_q,  head_d;
    logic [DATA_W-1:0] tail_q,  tail_d;
    logic              full_q,  full_d;
    logic              valid_q, valid_d;
    logic              do_push;
    logic              do_pop;

    // Next-state: push/pop bookkeeping and registered full/valid flags.
    always_comb begin
        cnt_d   = cnt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        do_push = push_i && !full_q;
        do_pop  = pop_i && valid_q;

        case ({do_push, do_pop})
            2'b10: begin
                if (cnt_q == '0) begin
                    head_d = data_i;
                end else begin
                    tail_d = data_i;
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
            2'b01: begin
                if (full_q) begin
                    head_d = tail_q;
                end
                cnt_d = cnt_q - CNT_W'(1);
            end
            2'b11: begin
                // Push is blocked when full, so this is the one-entry case:
                // the old head leaves and the new beat takes its place.
                head_d = data_i;
            end
            default: begin
            end
        endcase

        full_d  = (cnt_d == CNT_W'(FIFO_DEPTH));
        valid_d = (cnt_d != '0);
    end

    // State registers; reset empties the FIFO and clears the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            full_q  <= full_d;
            valid_q <= valid_d;
        end
    end

    assign full_o  = full_q;
    assign valid_o = valid_q;
    assign data_o  = head_q;

endmodule

// File: rtl/stream_demux.sv
// One-to-N stream demultiplexer. Each output has its own 2-entry buffer;
// beats whose select is out of range are consumed, dropped and counted.
module stream_demux
    import demux_pkg::*;
#(
    parameter int unsigned NUM_OUT = NUM_OUT_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SEL_W   = SEL_W_DEF,
    parameter int unsigned ERR_W   = ERR_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    input  logic                      err_clr,
    output logic [ERR_W-1:0]          err_cnt
);

    logic [NUM_OUT-1:0] full;
    logic [NUM_OUT-1:0] push;
    logic [NUM_OUT-1:0] pop;
    logic               sel_legal;
    logic               drop;
    logic [ERR_W-1:0]   err_q, err_d;

    // Select decode: ready comes only from registered full flags and in_sel.
    always_comb begin
        push      = '0;
        sel_legal = 1'b0;
        in_ready  = 1'b1;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_legal = 1'b1;
                in_ready  = !full[k];
                push[k]   = in_valid && !full[k];
            end
        end
        drop = in_valid && !sel_legal;
    end

    // Drop counter next state: clear wins, otherwise saturating increment.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end else if (drop && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign pop[k] = out_valid[k] && out_ready[k];

        demux_fifo2 #(
            .DATA_W (DATA_W)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push[k]),
            .pop_i   (pop[k]),
            .data_i  (in_data),
            .full_o  (full[k]),
            .valid_o (out_valid[k]),
            .data_o  (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux with NUM_OUT=3, DATA_W=8, SEL_W=2, ERR_W=8.
module tb_stream_demux;

    localparam int unsigned NUM_OUT = 3;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned ERR_W   = 8;
    localparam int unsigned NVEC    = 19;

    logic                      clk;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic [SEL_W-1:0]          in_sel;
    logic [NUM_OUT-1:0]        out_valid;
    logic [NUM_OUT-1:0]        out_ready;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic                      err_clr;
    logic [ERR_W-1:0]          err_cnt;

    int n_checks;
    int n_fail;

    typedef struct {
        logic               valid;
        logic [DATA_W-1:0]  data;
        logic [SEL_W-1:0]   sel;
        logic [NUM_OUT-1:0] oready;
        logic               clr;
        logic               exp_ir;
        logic [NUM_OUT-1:0] exp_ov;
        logic [23:0]        exp_od;
        logic [ERR_W-1:0]   exp_err;
    } vec_t;

    vec_t vecs [NVEC];

    stream_demux #(
        .NUM_OUT (NUM_OUT),
        .DATA_W  (DATA_W),
        .SEL_W   (SEL_W),
        .ERR_W   (ERR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [1:0] s,
                                input logic [2:0] orv, input logic c, input logic ir,
                                input logic [2:0] ov, input logic [23:0] od,
                                input logic [7:0] er);
        vec_t r;
        r.valid = v;   r.data = d;    r.sel = s;   r.oready = orv; r.clr = c;
        r.exp_ir = ir; r.exp_ov = ov; r.exp_od = od; r.exp_err = er;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s,
                         input logic [2:0] orv, input logic c);
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        out_ready = orv;
        err_clr   = c;
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 8'h00, 2'd0, 3'b111, 1'b0);

        // Expected outputs are the state left by all earlier edges.
        vecs[0]  = mk(1'b0, 8'h00, 2'd0, 3'b111, 1'b0, 1'b1, 3'b000, 24'h000000, 8'd0);
        vecs[1]  = mk(1'b1, 8'hA5, 2'd1, 3'b111, 1'b0, 1'b1, 3'b000, 24'h000000, 8'd0);
        vecs[2]  = mk(1'b0, 8'h00, 2'd0, 3'b111, 1'b0, 1'b1, 3'b010, 24'h00A500, 8'd0);
        vecs[3]  = mk(1'b0, 8'h00, 2'd0, 3'b111, 1'b0, 1'b1, 3'b000, 24'h00A500, 8'd0);
        vecs[4]  = mk(1'b1, 8'h01, 2'd2, 3'b011, 1'b0, 1'b1, 3'b000, 24'h00A500, 8'd0);
        vecs[5]  = mk(1'b1, 8'h02, 2'd2, 3'b011, 1'b0, 1'b1, 3'b100, 24'h01A500, 8'd0);
        vecs[6]  = mk(1'b1, 8'h5A, 2'd0, 3'b011, 1'b0, 1'b1, 3'b100, 24'h01A500, 8'd0);
        vecs[7]  = mk(1'b1, 8'h03, 2'd2, 3'b011, 1'b0, 1'b0, 3'b101, 24'h01A55A, 8'd0);
        vecs[8]  = mk(1'b1, 8'h03, 2'd2, 3'b011, 1'b0, 1'b0, 3'b100, 24'h01A55A, 8'd0);
        vecs[9]  = mk(1'b1, 8'h03, 2'd2, 3'b111, 1'b0, 1'b0, 3'b100, 24'h01A55A, 8'd0);
        vecs[10] = mk(1'b1, 8'h03, 2'd2, 3'b111, 1'b0, 1'b1, 3'b100, 24'h02A55A, 8'd0);
        vecs[11] = mk(1'b0, 8'h00, 2'd0, 3'b111, 1'b0, 1'b1, 3'b100, 24'h03A55A, 8'd0);
        vecs[12] = mk(1'b0, 8'h00, 2'd0, 3'b111, 1'b0, 1'b1, 3'b000, 24'h03A55A, 8'd0);
        vecs[13] = mk(1'b1, 8'h77, 2'd3, 3'b111, 1'b0, 1'b1, 3'b000, 24'h03A55A, 8'd0);
        vecs[14] = mk(1'b1, 8'h77, 2'd3, 3'b111, 1'b0, 1'b1, 3'b000, 24'h03A55A, 8'd1);
        vecs[15] = mk(1'b1, 8'h77, 2'd3, 3'b111, 1'b0, 1'b1, 3'b000, 24'h03A55A, 8'd2);
        vecs[16] = mk(1'b0, 8'h00, 2'd0, 3'b111, 1'b0, 1'b1, 3'b000, 24'h03A55A, 8'd3);
        vecs[17] = mk(1'b1, 8'h77, 2'd3, 3'b111, 1'b1, 1'b1, 3'b000, 24'h03A55A, 8'd3);
        vecs[18] = mk(1'b0, 8'h00, 2'd0, 3'b111, 1'b0, 1'b1, 3'b000, 24'h03A55A, 8'd0);

        // Reset held: everything cleared.
        repeat (2) @(posedge clk);
        #2;
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        chk("rst.out_data", 32'(out_data), 32'h0);
        chk("rst.err_cnt", 32'(err_cnt), 32'h0);
        #1 rst_n = 1'b1;
        cyc();

        // Table-driven single-cycle vectors.
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].sel, vecs[i].oready, vecs[i].clr);
            #1;
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
            chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            chk($sformatf("v%0d.out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
            chk($sformatf("v%0d.err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_err));
            cyc();
        end

        // Saturation: 300 illegal beats from zero stop at 255.
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 8'(i), 2'd3, 3'b111, 1'b0);
            if (i == 0 || i == 299) begin
                #1;
                chk($sformatf("sat%0d.in_ready", i), 32'(in_ready), 32'h1);
            end
            cyc();
        end
        drive(1'b0, 8'h00, 2'd0, 3'b111, 1'b0);
        #1;
        chk("sat.err_cnt", 32'(err_cnt), 32'd255);
        chk("sat.out_valid", 32'(out_valid), 32'h0);

        // Clear beats a simultaneous illegal acceptance.
        drive(1'b1, 8'h11, 2'd3, 3'b111, 1'b1);
        cyc();
        drive(1'b0, 8'h00, 2'd0, 3'b111, 1'b0);
        #1;
        chk("clr.err_cnt", 32'(err_cnt), 32'd0);

        // Mid-operation async reset with output 0 full.
        drive(1'b1, 8'h44, 2'd3, 3'b000, 1'b0);
        cyc();
        drive(1'b1, 8'hAA, 2'd0, 3'b000, 1'b0);
        cyc();
        drive(1'b1, 8'hBB, 2'd0, 3'b000, 1'b0);
        cyc();
        drive(1'b1, 8'hCC, 2'd0, 3'b000, 1'b0);
        #1;
        chk("full0.in_ready", 32'(in_ready), 32'h0);
        chk("full0.out_valid", 32'(out_valid), 32'b001);
        chk("full0.out_data0", 32'(out_data[7:0]), 32'hAA);
        chk("full0.err_cnt", 32'(err_cnt), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'h0);
        chk("arst.out_data", 32'(out_data), 32'h0);
        chk("arst.err_cnt", 32'(err_cnt), 32'h0);
        drive(1'b0, 8'h00, 2'd0, 3'b111, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("rel%0d.out_valid", i), 32'(out_valid), 32'h0);
            chk($sformatf("rel%0d.out_data", i), 32'(out_data), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
